// File: rtl/hdc_pkg.sv
// hdc_pkg: shared hypervector types, encoder states and the bind primitive.
// The factorization side uses the same hdc_bind so unbinding stays exact.
package hdc_pkg;

  localparam int HDC_VECTOR_LEN        = 32;
  localparam int HDC_NUM_FEATURES      = 3;
  localparam int HDC_NUM_CODEBOOK_BITS = 4;
  localparam int HDC_CB_SIZE = 1 << HDC_NUM_CODEBOOK_BITS;

  typedef logic [HDC_VECTOR_LEN-1:0] vec_t;

  typedef vec_t [HDC_NUM_FEATURES-1:0][HDC_CB_SIZE-1:0] codebook_t;

  typedef enum logic [1:0] {
    IDLE,
    BIND,
    MAJ,
    OUT
  } enc_state_t;

  // XOR binding is its own inverse.
  function automatic vec_t hdc_bind(
    input vec_t a,
    input vec_t b
  );
    return a ^ b;
  endfunction

  // Pseudo-random default codebook (xorshift32), only for standalone builds.
  function automatic codebook_t hdc_default_codebook();
    codebook_t  cb;
    logic [31:0] s;
    s = 32'h9E37_79B9;
    for (int f = 0; f < HDC_NUM_FEATURES; f++) begin
      for (int i = 0; i < HDC_CB_SIZE; i++) begin
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        cb[f][i] = vec_t'(s);
      end
    end
    return cb;
  endfunction

endpackage

// File: rtl/scene_encoder_bundle_majority.sv
// bundle_majority: per-bit object counters and majority/tie threshold.
// Present only when SCENE_BUNDLE_EN is defined.
`ifdef SCENE_BUNDLE_EN
module bundle_majority
  import hdc_pkg::*;
#(
  parameter int                    VECTOR_LEN  = HDC_VECTOR_LEN,
  parameter int                    MAX_OBJECTS = 3,
  parameter logic [VECTOR_LEN-1:0] TIE_VEC     = {(VECTOR_LEN/4){4'h5}}
) (
  input  logic                               i_clk,
  input  logic                               i_rstn,
  input  logic                               clr,
  input  logic                               acc_en,
  input  logic [VECTOR_LEN-1:0]              acc_vec,
  output logic [$clog2(MAX_OBJECTS+1)-1:0]   n,
  output logic                               full_nx,
  output logic [VECTOR_LEN-1:0]              maj
);

  localparam int NW = $clog2(MAX_OBJECTS+1);

  logic [VECTOR_LEN-1:0][NW-1:0] cnt;

  // Count ones per bit and objects; cleared once a scene is handed off.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
      n   <= '0;
    end else if (clr) begin
      cnt <= '0;
      n   <= '0;
    end else if (acc_en) begin
      n <= n + 1'b1;
      for (int b = 0; b < VECTOR_LEN; b++) begin
        cnt[b] <= cnt[b] + NW'(acc_vec[b]);
      end
    end
  end

  // The object being accumulated now fills the bundle.
  assign full_nx = (n == NW'(MAX_OBJECTS - 1));

  // Strict majority against n, tie bits taken from TIE_VEC.
  always_comb begin
    maj = '0;
    for (int b = 0; b < VECTOR_LEN; b++) begin
      logic [NW:0] dbl;
      logic [NW:0] ref_n;
      dbl   = {cnt[b], 1'b0};
      ref_n = {1'b0, n};
      if (dbl > ref_n)
        maj[b] = 1'b1;
      else if (dbl < ref_n)
        maj[b] = 1'b0;
      else
        maj[b] = TIE_VEC[b];
    end
  end

endmodule
`endif

// File: rtl/scene_encoder.sv
// scene_encoder: XOR-binds one codebook vector per feature into a scene.
// Define SCENE_BUNDLE_EN to bundle several objects by bitwise majority.
module scene_encoder
  import hdc_pkg::*;
#(
  parameter int VECTOR_LEN        = HDC_VECTOR_LEN,
  parameter int NUM_FEATURES      = HDC_NUM_FEATURES,
  parameter int NUM_CODEBOOK_BITS = HDC_NUM_CODEBOOK_BITS,
  parameter logic [NUM_FEATURES-1:0]
                  [(1<<NUM_CODEBOOK_BITS)-1:0]
                  [VECTOR_LEN-1:0] CODEBOOK = hdc_default_codebook(),
  parameter int                    MAX_OBJECTS = 3,
  parameter logic [VECTOR_LEN-1:0] TIE_VEC = {(VECTOR_LEN/4){4'h5}}
) (
  input  logic                                    i_clk,
  input  logic                                    i_rstn,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [NUM_FEATURES*NUM_CODEBOOK_BITS-1:0] i_idx,
  input  logic                                    i_last,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic [VECTOR_LEN-1:0]                   o_scene,
  output logic [$clog2(MAX_OBJECTS+1)-1:0]        o_num_objects
);

  localparam int IW = NUM_FEATURES * NUM_CODEBOOK_BITS;
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int NW = $clog2(MAX_OBJECTS+1);

  enc_state_t              state;
  logic [IW-1:0]           idx_q;
  logic [FW-1:0]           f_q;
  logic [VECTOR_LEN-1:0]   acc_q;
  logic [VECTOR_LEN-1:0]   acc_nx;
  logic                    last_f;
  logic                    out_hs;

  // Current feature's index always sits in the low bits of idx_q.
  assign acc_nx = hdc_bind(acc_q,
    CODEBOOK[f_q][idx_q[NUM_CODEBOOK_BITS-1:0]]);
  assign last_f = (f_q == FW'(NUM_FEATURES - 1));
  assign out_hs = o_valid && i_ready;

`ifdef SCENE_BUNDLE_EN
  logic                    last_q;
  logic [NW-1:0]           n;
  logic                    full_nx;
  logic [VECTOR_LEN-1:0]   maj;

  bundle_majority #(
    .VECTOR_LEN  (VECTOR_LEN),
    .MAX_OBJECTS (MAX_OBJECTS),
    .TIE_VEC     (TIE_VEC)
  ) u_bundle (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .clr     (out_hs),
    .acc_en  ((state == BIND) && last_f),
    .acc_vec (acc_nx),
    .n       (n),
    .full_nx (full_nx),
    .maj     (maj)
  );
`else
  wire unused_cfg = ^{i_last, TIE_VEC};
`endif

  // Control FSM with registered handshake and scene outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= IDLE;
      idx_q         <= '0;
      f_q           <= '0;
      acc_q         <= '0;
      o_ready       <= 1'b0;
      o_valid       <= 1'b0;
      o_scene       <= '0;
      o_num_objects <= '0;
`ifdef SCENE_BUNDLE_EN
      last_q        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            idx_q   <= i_idx;
            acc_q   <= '0;
            f_q     <= '0;
            o_ready <= 1'b0;
            state   <= BIND;
`ifdef SCENE_BUNDLE_EN
            last_q  <= i_last;
`endif
          end
        end
        BIND: begin
          acc_q <= acc_nx;
          f_q   <= f_q + 1'b1;
          if (last_f) begin
`ifdef SCENE_BUNDLE_EN
            if (last_q || full_nx) begin
              state <= MAJ;
            end else begin
              state   <= IDLE;
              o_ready <= 1'b1;
            end
`else
            o_scene       <= acc_nx;
            o_num_objects <= NW'(1);
            o_valid       <= 1'b1;
            state         <= OUT;
`endif
          end else begin
            idx_q <= idx_q >> NUM_CODEBOOK_BITS;
          end
        end
`ifdef SCENE_BUNDLE_EN
        MAJ: begin
          o_scene       <= maj;
          o_num_objects <= n;
          o_valid       <= 1'b1;
          state         <= OUT;
        end
`endif
        OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
